// File: rtl/sevenseg_reader.sv
// Receive-side monitor for the multiplexed seven-segment bus: debounces each digit's
// active-low pattern, decodes accepted patterns to hex and reassembles the 32-bit word.
module sevenseg_reader #(
    parameter int STABLE = 3  // consecutive identical samples to accept, 1..7
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_seg_valid,
    input  logic [2:0]  i_seg_sel,
    input  logic [6:0]  i_seg_in,
    output logic [31:0] o_hex_out,
    output logic [7:0]  o_known,
    output logic [7:0]  o_bad,
    output logic        o_word_valid,
    output logic        o_word_err
);

    localparam logic [2:0] STABLE_CNT = 3'(STABLE);
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [2:0] CNT_MAX    = 3'd7;

    // Returns {legal, nibble}; legal=0 for blank and for any non-hex pattern.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'b1000000: decode = {1'b1, 4'h0};
            7'b1111001: decode = {1'b1, 4'h1};
            7'b0100100: decode = {1'b1, 4'h2};
            7'b0110000: decode = {1'b1, 4'h3};
            7'b0011001: decode = {1'b1, 4'h4};
            7'b0010010: decode = {1'b1, 4'h5};
            7'b0000010: decode = {1'b1, 4'h6};
            7'b1111000: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0010000: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b0000011: decode = {1'b1, 4'hB};
            7'b1000110: decode = {1'b1, 4'hC};
            7'b0100001: decode = {1'b1, 4'hD};
            7'b0000110: decode = {1'b1, 4'hE};
            7'b0001110: decode = {1'b1, 4'hF};
            default:    decode = 5'b0_0000;
        endcase
    endfunction

    logic [6:0]  r_last [8];
    logic [2:0]  r_cnt  [8];
    logic [7:0]  r_seen;
    logic [31:0] r_hex;
    logic [7:0]  r_known;
    logic [7:0]  r_bad;
    logic        r_word_valid;
    logic        r_word_err;

    logic [7:0]  w_sel_mask;
    logic [2:0]  w_cnt_cur;
    logic [2:0]  w_cnt_new;
    logic        w_accept;
    logic        w_hit;
    logic        w_legal;
    logic [3:0]  w_nibble;
    logic        w_blank;
    logic [31:0] w_hex_next;
    logic [7:0]  w_known_next;
    logic [7:0]  w_bad_next;
    logic [7:0]  w_seen_next;
    logic        w_frame_done;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_sel_mask   = 8'b0000_0001 << i_seg_sel;
        w_cnt_cur    = r_cnt[i_seg_sel];
        w_cnt_new    = 3'd1;
        if (i_seg_in == r_last[i_seg_sel]) begin
            w_cnt_new = (w_cnt_cur == CNT_MAX) ? CNT_MAX : w_cnt_cur + 3'd1;
        end
        // Acceptance fires only on the exact crossing, so a held pattern is decoded once.
        w_accept     = i_seg_valid && (w_cnt_new == STABLE_CNT);
        w_hit        = i_seg_valid && (w_cnt_new >= STABLE_CNT);
        {w_legal, w_nibble} = decode(i_seg_in);
        w_blank      = (i_seg_in == SEG_BLANK);

        w_hex_next   = r_hex;
        w_known_next = r_known;
        w_bad_next   = r_bad;
        if (w_accept) begin
            if (w_legal) begin
                w_hex_next[{i_seg_sel, 2'b00} +: 4] = w_nibble;
                w_known_next = r_known | w_sel_mask;
                w_bad_next   = r_bad & ~w_sel_mask;
            end else begin
                w_known_next = r_known & ~w_sel_mask;
                w_bad_next   = w_blank ? (r_bad & ~w_sel_mask) : (r_bad | w_sel_mask);
            end
        end

        w_seen_next  = r_seen | (w_hit ? w_sel_mask : 8'h00);
        w_frame_done = &w_seen_next;
    end

    // NOTE: the per-digit history arrays are reset too, because a sample matching a
    // stale pattern would otherwise count toward acceptance after reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int d = 0; d < 8; d++) begin
                r_last[d] <= SEG_BLANK;
                r_cnt[d]  <= 3'd0;
            end
            r_seen       <= 8'h00;
            r_hex        <= 32'h0;
            r_known      <= 8'h00;
            r_bad        <= 8'h00;
            r_word_valid <= 1'b0;
            r_word_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers
            // update from the same pre-edge values.
            if (i_seg_valid) begin
                r_last[i_seg_sel] <= i_seg_in;
                r_cnt[i_seg_sel]  <= w_cnt_new;
            end
            r_hex        <= w_hex_next;
            r_known      <= w_known_next;
            r_bad        <= w_bad_next;
            // The completing sample closes its own frame; the next frame starts empty.
            r_word_valid <= w_frame_done;
            r_word_err   <= w_frame_done & (|w_bad_next);
            r_seen       <= w_frame_done ? 8'h00 : w_seen_next;
        end
    end

    assign o_hex_out    = r_hex;
    assign o_known      = r_known;
    assign o_bad        = r_bad;
    assign o_word_valid = r_word_valid;
    assign o_word_err   = r_word_err;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed bench for sevenseg_reader (STABLE=3): scan, debounce restart, bad and blank
// patterns, reset with a simultaneous sample, and continuous steady scanning.
module tb_sevenseg_reader;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_seg_valid;
    logic [2:0]  i_seg_sel;
    logic [6:0]  i_seg_in;
    logic [31:0] o_hex_out;
    logic [7:0]  o_known;
    logic [7:0]  o_bad;
    logic        o_word_valid;
    logic        o_word_err;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    sevenseg_reader #(.STABLE(3)) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_seg_valid  (i_seg_valid),
        .i_seg_sel    (i_seg_sel),
        .i_seg_in     (i_seg_in),
        .o_hex_out    (o_hex_out),
        .o_known      (o_known),
        .o_bad        (o_bad),
        .o_word_valid (o_word_valid),
        .o_word_err   (o_word_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_word_valid === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One valid sample; returns 1 ns after the edge that consumed it.
    task automatic send(input logic [2:0] sel, input logic [6:0] pat);
        i_seg_valid = 1'b1;
        i_seg_sel   = sel;
        i_seg_in    = pat;
        @(posedge clk);
        #1;
        i_seg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [3:0] steady [8] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};

    initial begin
        i_reset     = 1'b1;
        i_seg_valid = 1'b0;
        i_seg_sel   = 3'd0;
        i_seg_in    = 7'h7F;
        idle(2);
        i_reset = 1'b0;
        check("rst_hex",   o_hex_out, 32'h0);
        check("rst_known", 32'(o_known), 32'h0);
        check("rst_bad",   32'(o_bad), 32'h0);
        check("rst_wv",    32'(o_word_valid), 32'h0);
        check("rst_we",    32'(o_word_err), 32'h0);

        // Round-robin scan, digit d shows d+1, three samples each.
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 8; d++) begin
                send(3'(d), SEG[d + 1]);
                if (r == 1 && d == 7) check("scan_known_r2", 32'(o_known), 32'h00);
                if (r == 2 && d == 0) begin
                    check("scan_first_acc_hex", o_hex_out, 32'h0000_0001);
                    check("scan_first_acc_known", 32'(o_known), 32'h01);
                end
                if (r == 2 && d == 6) check("scan_wv_before", 32'(o_word_valid), 32'h0);
            end
        end
        check("scan_wv",    32'(o_word_valid), 32'h1);
        check("scan_we",    32'(o_word_err), 32'h0);
        check("scan_hex",   o_hex_out, 32'h8765_4321);
        check("scan_known", 32'(o_known), 32'hFF);
        idle(1);
        check("scan_wv_one_cycle", 32'(o_word_valid), 32'h0);
        check("scan_pulses", 32'(pulse_cnt), 32'd1);

        // Digit 2: an unstable 2 is never accepted, then a stable 1 is.
        send(3'd2, SEG[2]);
        send(3'd2, SEG[2]);
        check("d2_no_accept", o_hex_out, 32'h8765_4321);
        send(3'd2, SEG[1]);
        send(3'd2, SEG[1]);
        check("d2_restart", o_hex_out, 32'h8765_4321);
        send(3'd2, SEG[1]);
        check("d2_accept", o_hex_out, 32'h8765_4121);

        // Digit 4: illegal pattern held stable.
        send(3'd4, 7'b1010101);
        send(3'd4, 7'b1010101);
        check("d4_bad_early", 32'(o_bad), 32'h00);
        send(3'd4, 7'b1010101);
        check("d4_bad",   32'(o_bad), 32'h10);
        check("d4_known", 32'(o_known), 32'hEF);
        check("d4_hex",   o_hex_out, 32'h8765_4121);
        // Digits 2 and 4 are already seen; touch the rest to close the frame.
        send(3'd0, SEG[1]);
        send(3'd1, SEG[2]);
        send(3'd3, SEG[4]);
        send(3'd5, SEG[6]);
        send(3'd6, SEG[7]);
        check("bad_frame_wv_before", 32'(o_word_valid), 32'h0);
        send(3'd7, SEG[8]);
        check("bad_frame_wv", 32'(o_word_valid), 32'h1);
        check("bad_frame_we", 32'(o_word_err), 32'h1);
        idle(1);
        check("bad_frame_pulses", 32'(pulse_cnt), 32'd2);

        // Digit 0: show A, then blank it.
        for (int i = 0; i < 3; i++) send(3'd0, SEG[10]);
        check("d0_A", o_hex_out, 32'h8765_412A);
        send(3'd0, 7'h7F);
        send(3'd0, 7'h7F);
        check("d0_blank_early", 32'(o_known), 32'hEF);
        send(3'd0, 7'h7F);
        check("d0_blank_known", 32'(o_known), 32'hEE);
        check("d0_blank_bad",   32'(o_bad), 32'h10);
        check("d0_blank_hex",   o_hex_out, 32'h8765_412A);

        // Reset with a simultaneous valid sample; that sample must be discarded.
        send(3'd5, SEG[0]);
        i_reset = 1'b1;
        send(3'd3, SEG[9]);
        i_reset = 1'b0;
        check("mid_rst_hex",   o_hex_out, 32'h0);
        check("mid_rst_known", 32'(o_known), 32'h0);
        check("mid_rst_bad",   32'(o_bad), 32'h0);
        send(3'd3, SEG[9]);
        send(3'd3, SEG[9]);
        check("mid_rst_discard", 32'(o_known), 32'h00);
        send(3'd3, SEG[9]);
        check("mid_rst_accept_hex",   o_hex_out, 32'h0000_9000);
        check("mid_rst_accept_known", 32'(o_known), 32'h08);
        check("mid_rst_pulses", 32'(pulse_cnt), 32'd2);

        // Steady display, eight rounds: one pulse per completed round from round 3 on.
        for (int r = 0; r < 8; r++) begin
            for (int d = 0; d < 8; d++) begin
                send(3'(d), SEG[steady[d]]);
                check($sformatf("steady_wv_r%0d_d%0d", r, d), 32'(o_word_valid),
                      32'((r >= 2) && (d == 7)));
            end
            if (r == 2 || r == 7) begin
                check($sformatf("steady_hex_r%0d", r), o_hex_out, 32'hDEAD_BEEF);
                check($sformatf("steady_known_r%0d", r), 32'(o_known), 32'hFF);
                check($sformatf("steady_we_r%0d", r), 32'(o_word_err), 32'h0);
            end
        end
        idle(1);
        check("steady_pulses", 32'(pulse_cnt), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
